// File: rtl/sdram_pkg.sv
// Shared constants and FSM encoding for the SDRAM read-data serializer.
// The serializer top also honours the optional SDRAM_RD_SER_CRLF_EN build macro.
package sdram_pkg;

  localparam int SDRAM_DW       = 48;
  localparam int BYTES_PER_WORD = SDRAM_DW / 8;

  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SEND = 3'd2;
  localparam state_t ST_HOLD = 3'd3;
  localparam state_t ST_WAIT = 3'd4;

endpackage

// File: rtl/ser_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module ser_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage has no reset; only the pointers and flags define FIFO contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/sdram_rd_serializer.sv
// Buffers SDRAM read words and streams them MSB-byte-first to a UART TX under its rdy handshake.
// Define SDRAM_RD_SER_CRLF_EN to append 8'h0D 8'h0A after the last byte of every word.
module sdram_rd_serializer
  import sdram_pkg::*;
#(
  parameter int DATA_W     = SDRAM_DW,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_vld,
  input  logic              tx_rdy,
  output logic [7:0]        tx_dout,
  output logic              tx_dout_vld,
  output logic              fifo_full,
  output logic              overflow,
  output logic              busy
);

  localparam int NB = DATA_W / 8;

`ifdef SDRAM_RD_SER_CRLF_EN
  localparam int SH_W = DATA_W + 16;
  localparam int LAST = NB + 1;
`else
  localparam int SH_W = DATA_W;
  localparam int LAST = NB - 1;
`endif

  localparam int BW = $clog2(LAST + 2);

  state_t            state;
  logic [SH_W-1:0]   sh;
  logic [SH_W-1:0]   load_word;
  logic [BW-1:0]     bcnt;
  logic              hold_cnt;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              pop;

  assign pop = (state == ST_LOAD);

`ifdef SDRAM_RD_SER_CRLF_EN
  // The terminator rides in the shift register so it uses the same byte path.
  assign load_word = {fifo_dout, CR_BYTE, LF_BYTE};
`else
  assign load_word = fifo_dout;
`endif

  ser_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld),
    .pop   (pop),
    .din   (rd_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_dout_vld = (state == ST_SEND) && tx_rdy;
  assign busy        = (state != ST_IDLE) || !fifo_empty;

  // tx_dout is loaded ahead of SEND so the byte is already stable when the strobe fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sh       <= '0;
      bcnt     <= '0;
      hold_cnt <= 1'b0;
      tx_dout  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          // rd_vld is looked at directly because the registered empty flag lags the push.
          if (!fifo_empty || rd_vld) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          sh      <= load_word;
          tx_dout <= load_word[SH_W-1 -: 8];
          bcnt    <= '0;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_rdy) begin
            sh       <= sh << 8;
            hold_cnt <= 1'b0;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt) begin
            state <= ST_WAIT;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (tx_rdy) begin
            if (bcnt == BW'(LAST)) begin
              state <= fifo_empty ? ST_IDLE : ST_LOAD;
            end else begin
              bcnt    <= bcnt + BW'(1);
              tx_dout <= sh[SH_W-1 -: 8];
              state   <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (rd_vld && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule
